// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
//   Port 0 is the execute stage, port 1 the branch-compare/auxiliary unit.
//   Each port has a valid/ready request channel (operands + opcode) and a
//   valid/ready response channel backed by a single-entry result buffer.
//   Arbitration is round-robin: the loser of a contested cycle wins the next.
//
// Ports:
//   clk, rst_n                   clock (rising edge), async active-low reset
//   req{0,1}_valid/ready         request handshake
//   req{0,1}_a/_b/_op            request operands and ALU opcode
//   rsp{0,1}_valid/ready         response handshake
//   rsp{0,1}_result              buffered ALU result
//   alu_srca/alu_srcb/alu_op     drive to the shared ALU
//   alu_result                   combinational result from the ALU
module alu_arbiter #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OPCODE_LENGTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,

    input  logic                     req0_valid,
    output logic                     req0_ready,
    input  logic [DATA_WIDTH-1:0]    req0_a,
    input  logic [DATA_WIDTH-1:0]    req0_b,
    input  logic [OPCODE_LENGTH-1:0] req0_op,
    output logic                     rsp0_valid,
    input  logic                     rsp0_ready,
    output logic [DATA_WIDTH-1:0]    rsp0_result,

    input  logic                     req1_valid,
    output logic                     req1_ready,
    input  logic [DATA_WIDTH-1:0]    req1_a,
    input  logic [DATA_WIDTH-1:0]    req1_b,
    input  logic [OPCODE_LENGTH-1:0] req1_op,
    output logic                     rsp1_valid,
    input  logic                     rsp1_ready,
    output logic [DATA_WIDTH-1:0]    rsp1_result,

    output logic [DATA_WIDTH-1:0]    alu_srca,
    output logic [DATA_WIDTH-1:0]    alu_srcb,
    output logic [OPCODE_LENGTH-1:0] alu_op,
    input  logic [DATA_WIDTH-1:0]    alu_result
);

    // Round-robin pointer: the port favoured when both are eligible.
    logic rr;
    logic elig0, elig1;
    logic grant0, grant1;

    // A port may accept when its buffer is empty or is draining this cycle.
    assign elig0 = req0_valid & (~rsp0_valid | rsp0_ready);
    assign elig1 = req1_valid & (~rsp1_valid | rsp1_ready);

    // Gating with rst_n keeps ready and the ALU drive at zero during reset.
    assign grant0 = rst_n & elig0 & (~elig1 | ~rr);
    assign grant1 = rst_n & elig1 & (~elig0 |  rr);

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    always_comb begin
        alu_srca = '0;
        alu_srcb = '0;
        alu_op   = '0;
        if (grant0) begin
            alu_srca = req0_a;
            alu_srcb = req0_b;
            alu_op   = req0_op;
        end else if (grant1) begin
            alu_srca = req1_a;
            alu_srcb = req1_b;
            alu_op   = req1_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr <= 1'b0;
        end else if (grant0) begin
            rr <= 1'b1;
        end else if (grant1) begin
            rr <= 1'b0;
        end
    end

    // A new grant reloads the buffer even while it drains, so back-to-back
    // results flow without a bubble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp0_valid  <= 1'b0;
            rsp0_result <= '0;
        end else if (grant0) begin
            rsp0_valid  <= 1'b1;
            rsp0_result <= alu_result;
        end else if (rsp0_ready) begin
            rsp0_valid  <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp1_valid  <= 1'b0;
            rsp1_result <= '0;
        end else if (grant1) begin
            rsp1_valid  <= 1'b1;
            rsp1_result <= alu_result;
        end else if (rsp1_ready) begin
            rsp1_valid  <= 1'b0;
        end
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single combinational ALU between two requesters: port 0 is the execute stage, port 1 is the branch-compare/auxiliary unit. Each requester uses a valid/ready request channel and a valid/ready response channel. The block arbitrates round-robin, drives the ALU operand and opcode inputs, and registers the ALU result into a per-requester single-entry response buffer. It sits between the requesters and the ALU; the ALU needs no changes.

Parameters:
DATA_WIDTH, 32, operand and result width
OPCODE_LENGTH, 4, ALU operation code width (same encoding as the ALU)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  requester 0 operation accepted this cycle
req0_a  input  DATA_WIDTH  requester 0 SrcA
req0_b  input  DATA_WIDTH  requester 0 SrcB
req0_op  input  OPCODE_LENGTH  requester 0 Operation
rsp0_valid  output  1  requester 0 result available
rsp0_ready  input  1  requester 0 consumes result
rsp0_result  output  DATA_WIDTH  requester 0 result
req1_valid, req1_ready, req1_a, req1_b, req1_op  same as port 0, for requester 1
rsp1_valid, rsp1_ready, rsp1_result  same as port 0, for requester 1
alu_srca  output  DATA_WIDTH  to ALU SrcA
alu_srcb  output  DATA_WIDTH  to ALU SrcB
alu_op  output  OPCODE_LENGTH  to ALU Operation
alu_result  input  DATA_WIDTH  from ALU ALUResult (combinational)

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous, active-low.
- Reset values: rsp0_valid = rsp1_valid = 0; rsp0_result = rsp1_result = 0; round-robin pointer rr = 0 (port 0 favoured).
  - While rst_n = 0: req0_ready = req1_ready = 0, alu_srca = alu_srcb = 0, alu_op = 0.
- Eligibility (combinational): port i is eligible when reqi_valid = 1 AND (rspi_valid = 0 OR rspi_ready = 1).
  - A drain and a new accept on the same port in the same cycle are allowed.
- Grant (combinational, at most one port per cycle):
  - Only one port eligible: grant it.
  - Both eligible: grant port rr.
  - Neither eligible: no grant.
- reqi_ready = grant_i. A transfer occurs when reqi_valid & reqi_ready.
- Request stability: requesters hold valid, a, b and op stable until ready. The block does not check this.
- ALU drive: alu_srca/alu_srcb/alu_op = operands of the granted port. With no grant, drive 0/0/0. Opcodes pass through unmodified, including undefined codes (ALU returns 0 for those).
- Pointer update on each grant: rr <= 1 - granted port, so the loser of a contested cycle wins the next contest. With no grant, rr holds.
- Response capture at the rising edge ending a grant cycle:
  - rspi_result <= alu_result.
  - rspi_valid <= 1.
  - Latency: accept at edge N, result visible with rspi_valid = 1 after edge N. One operation per cycle total throughput.
- Response hold: rspi_valid and rspi_result stay stable until the rspi_ready handshake.
  - On rspi_valid & rspi_ready with no new grant to port i: rspi_valid <= 0; rspi_result holds its last value.
  - With a simultaneous new grant: rspi_valid stays 1, new result loaded.
- Backpressure isolation: a stalled response on one port (rspi_ready = 0, rspi_valid = 1) blocks only that port's new requests. The other port may take every cycle.
- rspi_ready while rspi_valid = 0: ignored.
- Reset mid-operation: an in-flight accept or pending response is discarded. All state returns to reset values immediately, without waiting for a clock edge.
- No other state. Expected implementation: FSM-free datapath with rr flop, two valid flops, two result registers.

Test Plan:
1. Single op, no contention: req0 ADD (op 0010), a = 5, b = 7 -> req0_ready = 1 that cycle, alu_op = 0010; next cycle rsp0_valid = 1, rsp0_result = 12. Hold rsp0_ready = 0 for 3 cycles -> rsp0_result remains 12.
2. Contention after reset: req0 AND(0xF0, 0x3C) and req1 SUB(10, 3) both valid, both rsp_ready = 1 -> cycle 1 grants port 0 (rsp0_result = 0x30); cycle 2 grants port 1 (rsp1_result = 7).
3. Fairness: both ports continuously valid with ADD, all rsp_ready = 1, for 8 cycles -> grants alternate 0,1,0,1,..., 4 each.
4. Backpressure isolation: rsp0_valid = 1, rsp0_ready = 0, req0 and req1 valid -> req0_ready = 0 every cycle; req1_ready = 1 every cycle; rsp1 results flow; rsp0_result unchanged.
5. Drain plus accept: rsp0_valid = 1 (result 12), rsp0_ready = 1, req0 OR(0x1, 0x2) in the same cycle -> req0_ready = 1; next cycle rsp0_valid = 1, rsp0_result = 3, with no bubble.
6. Async reset mid-operation: grant port 1 SLL(1, 4), then assert rst_n = 0 between clock edges before the response drains -> rsp1_valid = 0 and rsp1_result = 0 immediately. After release, the first contested cycle grants port 0.
